// File: rtl/dma_engine.sv
// Purpose : two-beat command responder that copies words between device and memory space over a shared bus.
// Latency : bus_req one cycle after beat1, first RD one cycle after bus_gnt, 2 cycles/word, done_irq on DONE entry.
// Backpress: bus_gnt stalls the engine in REQ; cmd_valid is ignored while a transfer is in flight.
//
// Ports:
//   clk, rst              clock (rising) and async active-low reset
//   cmd_valid/addr/data   command beats: beat0 = device addr + word count,
//                         beat1 = memory addr + direction (bit0: 1 = dev->mem)
//   done_irq, irq_ack     level completion interrupt and its acknowledge
//   bus_req, bus_gnt      shared-bus arbitration handshake
//   bus_oe, m_addr, m_w_notr, m_wdata, m_rdata   bus master signals

module dma_engine #(
    parameter int SZ  = 8,
    parameter int WSZ = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    input  logic [SZ-1:0]  cmd_addr,
    input  logic [WSZ-1:0] cmd_data,
    output logic           done_irq,
    input  logic           irq_ack,
    output logic           bus_req,
    input  logic           bus_gnt,
    output logic           bus_oe,
    output logic [SZ-1:0]  m_addr,
    output logic           m_w_notr,
    output logic [WSZ-1:0] m_wdata,
    input  logic [WSZ-1:0] m_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD1 = 3'd1,
        REQ  = 3'd2,
        RD   = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state;
    logic [SZ-1:0]  dev_addr;
    logic [SZ-1:0]  src;
    logic [SZ-1:0]  dst;
    logic [WSZ-1:0] count;

    // m_wdata doubles as the read buffer: it captures m_rdata at the end of RD
    // and is presented during the following WR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dev_addr <= '0;
            src      <= '0;
            dst      <= '0;
            count    <= '0;
            done_irq <= 1'b0;
            bus_req  <= 1'b0;
            bus_oe   <= 1'b0;
            m_addr   <= '0;
            m_w_notr <= 1'b0;
            m_wdata  <= '0;
        end else begin
            // Acknowledge clears by default; a DONE entry later in this block
            // overrides it so that a coincident set wins.
            if (irq_ack) begin
                done_irq <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dev_addr <= cmd_addr;
                        count    <= cmd_data;
                        done_irq <= 1'b0;
                        state    <= CMD1;
                    end
                end

                CMD1: begin
                    if (cmd_valid) begin
                        // Resolve direction once into source/destination pointers.
                        src <= cmd_data[0] ? dev_addr : cmd_addr;
                        dst <= cmd_data[0] ? cmd_addr : dev_addr;
                        if (count != '0) begin
                            bus_req <= 1'b1;
                            state   <= REQ;
                        end else begin
                            done_irq <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end

                REQ: begin
                    if (bus_gnt) begin
                        bus_oe   <= 1'b1;
                        m_w_notr <= 1'b0;
                        m_addr   <= src;
                        state    <= RD;
                    end
                end

                RD: begin
                    m_wdata  <= m_rdata;
                    m_addr   <= dst;
                    m_w_notr <= 1'b1;
                    state    <= WR;
                end

                WR: begin
                    src      <= src + 1'b1;
                    dst      <= dst + 1'b1;
                    count    <= count - 1'b1;
                    m_w_notr <= 1'b0;
                    if (count == WSZ'(1)) begin
                        // Last word: release the bus; m_addr/m_wdata hold.
                        bus_oe   <= 1'b0;
                        bus_req  <= 1'b0;
                        done_irq <= 1'b1;
                        state    <= DONE;
                    end else begin
                        m_addr <= src + 1'b1;
                        state  <= RD;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Purpose : randomized and directed checking of dma_engine against a word-copy reference model.
// Latency : expects done_irq 2*count+1+grant_delay cycles after beat1 (same edge for count 0).
// Backpress: grant is withheld for a chosen number of cycles to exercise the REQ stall.

module tb_dma_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       done_irq;
    logic       irq_ack;
    logic       bus_req;
    logic       bus_gnt;
    logic       bus_oe;
    logic [7:0] m_addr;
    logic       m_w_notr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  seed    [256];
    logic        load;
    logic [16:0] bus_log [$];
    int          req_cycles = 0;
    int          oe_violations = 0;

    always #5 clk = ~clk;

    dma_engine #(.SZ(8), .WSZ(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .done_irq  (done_irq),
        .irq_ack   (irq_ack),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_oe    (bus_oe),
        .m_addr    (m_addr),
        .m_w_notr  (m_w_notr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    // Flat 256-word bus slave: combinational read, write on the clock edge.
    assign m_rdata = mem[m_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed[i];
        end else if (bus_oe && m_w_notr) begin
            mem[m_addr] <= m_wdata;
        end
    end

    // Mid-cycle bus monitor: {write, addr, data} for every driven cycle.
    always @(negedge clk) begin
        if (bus_oe) bus_log.push_back({m_w_notr, m_addr, m_w_notr ? m_wdata : m_rdata});
        if (bus_req) req_cycles++;
        if (!bus_oe && m_w_notr) oe_violations++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // One full command; the reference copies word by word in order, so
    // overlapping or wrapping regions come out the same as on the bus.
    task automatic run_xfer(input logic [7:0] dev, input logic [7:0] cnt,
                            input logic [7:0] mema, input logic dir, input int gd,
                            input bit ack_early, input bit do_ack, input bit junk);
        logic [7:0]  s, t, v;
        logic [16:0] exp_q [$];
        int base, req0, lat, exp_lat, mism, n;
        bit got, hold_ok;
        s = dir ? dev : mema;
        t = dir ? mema : dev;
        for (int i = 0; i < int'(cnt); i++) begin
            v = ref_mem[s];
            exp_q.push_back({1'b0, s, v});
            exp_q.push_back({1'b1, t, v});
            ref_mem[t] = v;
            s = s + 8'd1;
            t = t + 8'd1;
        end
        exp_lat = (cnt == 8'd0) ? 0 : 2 * int'(cnt) + 1 + gd;
        base = bus_log.size();
        req0 = req_cycles;
        irq_ack = ack_early;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = dev; cmd_data = cnt;
        @(negedge clk);
        check("beat0_clr", 32'(done_irq), 32'd0);
        cmd_addr = mema; cmd_data = {7'd0, dir};
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; got = 1'b0; hold_ok = 1'b1;
        while (lat < 2000) begin
            if (done_irq) begin
                got = 1'b1;
                break;
            end
            if (lat <= gd && (bus_req !== 1'b1 || bus_oe !== 1'b0)) hold_ok = 1'b0;
            bus_gnt = (lat >= gd);
            if (junk) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_addr  = 8'($urandom);
                cmd_data  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        bus_gnt = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_idle_bus", {30'd0, bus_req, bus_oe}, 32'd0);
        if (cnt == 8'd0) check("no_req", 32'(req_cycles - req0), 32'd0);
        else check("req_hold", 32'(hold_ok), 32'd1);

        n = bus_log.size() - base;
        check("ops_n", 32'(n), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (bus_log[base + i] !== exp_q[i]) mism++;
        check("ops", 32'(mism), 32'd0);
        check("mem", 32'(mem_diffs()), 32'd0);

        if (ack_early) begin
            @(negedge clk);
            check("ack_clr", 32'(done_irq), 32'd0);
            irq_ack = 1'b0;
        end else if (do_ack) begin
            irq_ack = 1'b1;
            @(negedge clk);
            irq_ack = 1'b0;
            check("ack_clr", 32'(done_irq), 32'd0);
        end else begin
            @(negedge clk);
            check("irq_hold", 32'(done_irq), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        irq_ack = 1'b0; bus_gnt = 1'b0;
        for (int i = 0; i < 256; i++) seed[i] = 8'($urandom);
        seed[5] = 8'ha1; seed[6] = 8'ha2; seed[7] = 8'ha3;
        seed[40] = 8'h11; seed[41] = 8'h22;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed[i];

        repeat (3) @(negedge clk);
        check("rst_done_irq", 32'(done_irq), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_oe", 32'(bus_oe), 32'd0);
        check("rst_m_w_notr", 32'(m_w_notr), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_wdata", 32'(m_wdata), 32'd0);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // dev 5..7 -> mem 12..14
        run_xfer(8'd5, 8'd3, 8'd12, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        check("t1_mem12", 32'(mem[12]), 32'ha1);
        check("t1_mem13", 32'(mem[13]), 32'ha2);
        check("t1_mem14", 32'(mem[14]), 32'ha3);
        // mem 40..41 -> dev 20..21
        run_xfer(8'd20, 8'd2, 8'd40, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t2_dev20", 32'(mem[20]), 32'h11);
        check("t2_dev21", 32'(mem[21]), 32'h22);
        // zero count, left unacknowledged so the next beat0 must clear it
        run_xfer(8'd5, 8'd0, 8'd12, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        // grant withheld 5 cycles, stray command beats during the transfer
        run_xfer(8'h50, 8'd2, 8'h60, 1'b1, 5, 1'b0, 1'b1, 1'b1);
        // device address wrap
        run_xfer(8'hFE, 8'd3, 8'h7E, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        // ack held high across DONE entry: set must win
        run_xfer(8'h10, 8'd1, 8'hC0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Reset during the second WR of a 4-word copy 0x30 -> 0x90.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 8'h30; cmd_data = 8'd4;
        @(negedge clk);
        cmd_addr = 8'h90; cmd_data = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0; bus_gnt = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_in_wr", {30'd0, bus_oe, m_w_notr}, 32'd3);
        rst = 1'b0;
        #1;
        check("abort_outs", {20'd0, done_irq, bus_req, bus_oe, m_w_notr, m_addr}, 32'd0);
        check("abort_wdata", 32'(m_wdata), 32'd0);
        bus_gnt = 1'b0;
        ref_mem[8'h90] = ref_mem[8'h30];
        repeat (3) @(negedge clk);
        check("abort_no_irq", 32'(done_irq), 32'd0);
        check("abort_mem", 32'(mem_diffs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        run_xfer(8'h31, 8'd2, 8'h91, 1'b1, 0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_xfer(8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        check("oe_low_wnotr", 32'(oe_violations), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
